// File: rtl/pipeline_ctrl_gen.sv
// Pipeline hazard controller: decodes per-stage stall requests into stall/bubble masks,
// sequences exception flushes with a PC redirect, and tracks stall duration.
module pipeline_ctrl_gen #(
  parameter int NUM_STAGES   = 6,
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_WIDTH   = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_STAGES-1:0] i_stall_req,
  input  logic                  i_stall_all,
  input  logic                  i_flush_req,
  input  logic [ADDR_WIDTH-1:0] i_flush_pc,
  output logic [NUM_STAGES-1:0] o_stall,
  output logic [NUM_STAGES-1:0] o_bubble,
  output logic [NUM_STAGES-1:0] o_flush,
  output logic                  o_new_pc_valid,
  output logic [ADDR_WIDTH-1:0] o_new_pc,
  output logic                  o_stall_timeout,
  output logic [CNT_WIDTH-1:0]  o_stall_cycles
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t                r_state;
  logic [FCW-1:0]        r_flush_cnt;
  logic                  r_pc_pending;
  logic [ADDR_WIDTH-1:0] r_new_pc;
  logic [WDOG_WIDTH-1:0] r_wd_cnt;
  logic                  r_timeout;
  logic [CNT_WIDTH-1:0]  r_stall_cycles;

  logic [NUM_STAGES-1:0] w_req_stall;
  logic [NUM_STAGES-1:0] w_req_bubble;
  logic                  w_any_stall;

  // A request at stage h holds every stage at or below h; the stage just above gets a NOP.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_decode
    assign w_req_stall[gi] = |i_stall_req[NUM_STAGES-1:gi];
    if (gi == 0) begin : g_first
      assign w_req_bubble[gi] = 1'b0;
    end else begin : g_rest
      assign w_req_bubble[gi] = w_req_stall[gi-1] & ~w_req_stall[gi];
    end
  end

  always_comb begin
    o_stall        = '0;
    o_bubble       = '0;
    o_flush        = '0;
    o_new_pc_valid = 1'b0;
    if (i_stall_all) begin
      o_stall = '1;
    end else if (r_state == S_FLUSH) begin
      o_flush        = {1'b0, {(NUM_STAGES-1){1'b1}}};
      o_new_pc_valid = r_pc_pending;
    end else begin
      o_stall  = w_req_stall;
      o_bubble = w_req_bubble;
    end
  end

  // r_pc_pending keeps the redirect pulse armed until the first FLUSH cycle that is not frozen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_flush_cnt  <= '0;
      r_pc_pending <= 1'b0;
      r_new_pc     <= '0;
    end else if (!i_stall_all) begin
      case (r_state)
        S_IDLE: begin
          if (i_flush_req) begin
            r_state      <= S_FLUSH;
            r_new_pc     <= i_flush_pc;
            r_flush_cnt  <= FLUSH_LAST;
            r_pc_pending <= 1'b1;
          end
        end
        S_FLUSH: begin
          r_pc_pending <= 1'b0;
          if (r_flush_cnt == '0) r_state <= S_IDLE;
          else                   r_flush_cnt <= r_flush_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_any_stall = |o_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd_cnt       <= '0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (w_any_stall) begin
        if (r_wd_cnt == '1) r_timeout <= 1'b1;
        else                r_wd_cnt  <= r_wd_cnt + 1'b1;
      end else begin
        r_wd_cnt <= '0;
      end
      if (o_stall[0] && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign o_new_pc        = r_new_pc;
  assign o_stall_timeout = r_timeout;
  assign o_stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl_gen.sv
// Directed bench for pipeline_ctrl_gen: stall decode, flush sequencing, freeze, watchdog, async reset.
module tb_pipeline_ctrl_gen;
  localparam int NS = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] stall_req;
  logic          stall_all;
  logic          flush_req;
  logic [31:0]   flush_pc;
  logic [NS-1:0] stall, bubble, flush;
  logic          new_pc_valid;
  logic [31:0]   new_pc;
  logic          stall_timeout;
  logic [3:0]    stall_cycles;

  int n_total = 0;
  int n_bad   = 0;

  pipeline_ctrl_gen #(
    .NUM_STAGES(NS), .ADDR_WIDTH(32), .FLUSH_CYCLES(2), .WDOG_WIDTH(3), .CNT_WIDTH(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_stall_req(stall_req), .i_stall_all(stall_all),
    .i_flush_req(flush_req), .i_flush_pc(flush_pc), .o_stall(stall), .o_bubble(bubble),
    .o_flush(flush), .o_new_pc_valid(new_pc_valid), .o_new_pc(new_pc),
    .o_stall_timeout(stall_timeout), .o_stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one edge, then settle away from it before inputs change or outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_masks(input string tag, input logic [NS-1:0] s, input logic [NS-1:0] b,
                             input logic [NS-1:0] f);
    #2;
    check_val({tag, ".stall"},  32'(stall),  32'(s));
    check_val({tag, ".bubble"}, 32'(bubble), 32'(b));
    check_val({tag, ".flush"},  32'(flush),  32'(f));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  logic [NS-1:0] t_req [4]  = '{6'b000100, 6'b010100, 6'b100000, 6'b000001};
  logic [NS-1:0] t_stl [4]  = '{6'b000111, 6'b011111, 6'b111111, 6'b000001};
  logic [NS-1:0] t_bub [4]  = '{6'b001000, 6'b100000, 6'b000000, 6'b000010};

  initial begin
    rst = 1'b1; stall_req = '0; stall_all = 1'b0; flush_req = 1'b0; flush_pc = '0;
    #3;
    check_masks("reset", 6'b0, 6'b0, 6'b0);
    check_val("reset.npv",     32'(new_pc_valid),  32'd0);
    check_val("reset.new_pc",  new_pc,             32'd0);
    check_val("reset.timeout", 32'(stall_timeout), 32'd0);
    check_val("reset.cycles",  32'(stall_cycles),  32'd0);
    step();
    rst = 1'b0;
    step();

    // T1/T2: stall decode table
    for (int i = 0; i < 4; i++) begin
      stall_req = t_req[i];
      check_masks($sformatf("decode%0d", i), t_stl[i], t_bub[i], 6'b0);
      step();
    end
    stall_req = '0;
    check_masks("decode_none", 6'b0, 6'b0, 6'b0);
    stall_req = 6'b000100; stall_all = 1'b1;
    check_masks("freeze_idle", 6'b111111, 6'b0, 6'b0);
    stall_all = 1'b0; stall_req = '0;

    // T3: flush with stall_req held
    do_reset();
    stall_req = 6'b001000; flush_req = 1'b1; flush_pc = 32'hBFC00380;
    check_masks("t3.n", 6'b001111, 6'b010000, 6'b0);
    step();
    flush_req = 1'b0;
    check_masks("t3.n1", 6'b0, 6'b0, 6'b011111);
    check_val("t3.n1.npv",    32'(new_pc_valid), 32'd1);
    check_val("t3.n1.new_pc", new_pc,            32'hBFC00380);
    step();
    flush_req = 1'b1; flush_pc = 32'h0000DEAD;
    check_masks("t3.n2", 6'b0, 6'b0, 6'b011111);
    check_val("t3.n2.npv", 32'(new_pc_valid), 32'd0);
    step();
    flush_req = 1'b0;
    check_masks("t3.n3", 6'b001111, 6'b010000, 6'b0);
    check_val("t3.n3.new_pc", new_pc, 32'hBFC00380);
    step();
    check_masks("t3.n4", 6'b001111, 6'b010000, 6'b0);
    stall_req = '0;

    // T4: freeze during the first FLUSH cycle
    do_reset();
    flush_req = 1'b1; flush_pc = 32'h00001234;
    step();
    flush_req = 1'b0;
    stall_all = 1'b1;
    for (int k = 0; k < 3; k++) begin
      flush_req = 1'b1; flush_pc = 32'h0000BEEF;
      check_masks($sformatf("t4.frz%0d", k), 6'b111111, 6'b0, 6'b0);
      check_val($sformatf("t4.frz%0d.npv", k), 32'(new_pc_valid), 32'd0);
      step();
    end
    stall_all = 1'b0; flush_req = 1'b0;
    check_masks("t4.res1", 6'b0, 6'b0, 6'b011111);
    check_val("t4.res1.npv",    32'(new_pc_valid), 32'd1);
    check_val("t4.res1.new_pc", new_pc,            32'h00001234);
    step();
    check_masks("t4.res2", 6'b0, 6'b0, 6'b011111);
    check_val("t4.res2.npv", 32'(new_pc_valid), 32'd0);
    step();
    check_masks("t4.idle", 6'b0, 6'b0, 6'b0);

    // T5: watchdog with limit 7 and counter saturation at 15
    do_reset();
    stall_req = 6'b000001;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 7) check_val("t5.wd_e7", 32'(stall_timeout), 32'd0);
    end
    check_val("t5.wd_e8",   32'(stall_timeout), 32'd1);
    check_val("t5.cycles8", 32'(stall_cycles),  32'd8);
    stall_req = '0;
    step();
    check_val("t5.sticky",  32'(stall_timeout), 32'd1);
    check_val("t5.hold8",   32'(stall_cycles),  32'd8);
    stall_req = 6'b000001;
    for (int k = 0; k < 7; k++) step();
    check_val("t5.cyc15",   32'(stall_cycles),  32'd15);
    for (int k = 0; k < 3; k++) step();
    check_val("t5.sat",     32'(stall_cycles),  32'd15);
    stall_req = '0;

    // T6: asynchronous reset in the middle of FLUSH
    flush_req = 1'b1; flush_pc = 32'hCAFE0000;
    step();
    flush_req = 1'b0;
    check_masks("t6.flushing", 6'b0, 6'b0, 6'b011111);
    #1 rst = 1'b1;
    #1;
    check_masks("t6.rst", 6'b0, 6'b0, 6'b0);
    check_val("t6.rst.new_pc",  new_pc,             32'd0);
    check_val("t6.rst.cycles",  32'(stall_cycles),  32'd0);
    check_val("t6.rst.timeout", 32'(stall_timeout), 32'd0);
    rst = 1'b0;
    step();
    flush_req = 1'b1; flush_pc = 32'h80000180;
    step();
    flush_req = 1'b0;
    check_masks("t6.redir", 6'b0, 6'b0, 6'b011111);
    check_val("t6.redir.npv",    32'(new_pc_valid), 32'd1);
    check_val("t6.redir.new_pc", new_pc,            32'h80000180);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end
endmodule
